// File: rtl/wb_pkg.sv
// Write-back stage shared types: result source select, FSM states,
// and load funct3 encodings.
package wb_pkg;

  typedef enum logic [1:0] {
    SEL_ALU = 2'd0,
    SEL_MEM = 2'd1,
    SEL_PC4 = 2'd2,
    SEL_CSR = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_READY    = 2'd1,
    ST_WAIT_MEM = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_if.sv
// Write-back stage bundle: upstream handshake, load response,
// flush, register-file write port and retire information.
interface wb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int RW = $clog2(NREG);
  localparam int AW = $clog2(XLEN / 8);

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_wb_sel;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_plus4;
  logic [XLEN-1:0] in_csr_rdata;
  logic [2:0]      in_load_funct3;
  logic [AW-1:0]   in_addr_lo;
  logic [RW-1:0]   in_rd;
  logic            in_reg_write;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            flush;
  logic            rf_we;
  logic [RW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            retire_valid;
  logic [63:0]     instret;

  modport master (
    output in_valid, in_wb_sel, in_alu_result,
    output in_pc_plus4, in_csr_rdata,
    output in_load_funct3, in_addr_lo,
    output in_rd, in_reg_write,
    output mem_rvalid, mem_rdata, flush,
    input  in_ready, rf_we, rf_waddr, rf_wdata,
    input  retire_valid, instret
  );

  modport slave (
    input  in_valid, in_wb_sel, in_alu_result,
    input  in_pc_plus4, in_csr_rdata,
    input  in_load_funct3, in_addr_lo,
    input  in_rd, in_reg_write,
    input  mem_rvalid, mem_rdata, flush,
    output in_ready, rf_we, rf_waddr, rf_wdata,
    output retire_valid, instret
  );

endinterface

// File: rtl/wb_load_align.sv
// Load data lane select and size/sign extension.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = $clog2(XLEN / 8)
) (
  input  logic [2:0]      i_funct3,
  input  logic [AW-1:0]   i_addr_lo,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_sh;
  logic [63:0]     w_s;
  logic [63:0]     w_ext;

  assign w_sh = i_rdata >> {i_addr_lo, 3'b000};
  assign w_s  = 64'(w_sh);

  // Build at 64 bits and truncate, so XLEN=32 needs no special case.
  always_comb begin
    w_ext = w_s;
    unique case (i_funct3)
      F3_LB:   w_ext = {{56{w_s[7]}}, w_s[7:0]};
      F3_LH:   w_ext = {{48{w_s[15]}}, w_s[15:0]};
      F3_LW:   w_ext = {{32{w_s[31]}}, w_s[31:0]};
      F3_LD:   w_ext = w_s;
      F3_LBU:  w_ext = {56'd0, w_s[7:0]};
      F3_LHU:  w_ext = {48'd0, w_s[15:0]};
      F3_LWU:  w_ext = {32'd0, w_s[31:0]};
      default: w_ext = w_s;
    endcase
  end

  assign o_data = w_ext[XLEN-1:0];

endmodule

// File: rtl/wb_stage.sv
// Single-entry write-back stage: result select, load alignment,
// register-file write and instret counting.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic clk,
  input logic rst,
  wb_if.slave bus
);
  localparam int RW = $clog2(NREG);
  localparam int AW = $clog2(XLEN / 8);

  wb_state_e       r_state;
  wb_state_e       w_nstate;
  wb_sel_e         r_sel;
  logic [RW-1:0]   r_rd;
  logic            r_rw;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_pc4;
  logic [XLEN-1:0] r_csr;
  logic [2:0]      r_f3;
  logic [AW-1:0]   r_lo;
  logic [63:0]     r_instret;

  logic            w_commit;
  logic            w_capture;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_wdata;

  assign w_commit = !rst && !bus.flush &&
    ((r_state == ST_READY) ||
     (r_state == ST_WAIT_MEM && bus.mem_rvalid));

  assign bus.in_ready = !rst && !bus.flush &&
    ((r_state == ST_EMPTY) || w_commit);

  assign w_capture = bus.in_valid && bus.in_ready;

  always_comb begin
    w_nstate = r_state;
    if (bus.flush)
      w_nstate = ST_EMPTY;
    else if (w_capture)
      w_nstate = (wb_sel_e'(bus.in_wb_sel) == SEL_MEM) ?
        ST_WAIT_MEM : ST_READY;
    else if (w_commit)
      w_nstate = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_instret <= 64'd0;
    end else begin
      r_state <= w_nstate;
      if (w_commit)
        r_instret <= r_instret + 64'd1;
    end
  end

  // Entry payload needs no reset; validity lives in r_state.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_sel <= wb_sel_e'(bus.in_wb_sel);
      r_rd  <= bus.in_rd;
      r_rw  <= bus.in_reg_write;
      r_alu <= bus.in_alu_result;
      r_pc4 <= bus.in_pc_plus4;
      r_csr <= bus.in_csr_rdata;
      r_f3  <= bus.in_load_funct3;
      r_lo  <= bus.in_addr_lo;
    end
  end

  wb_load_align #(.XLEN(XLEN), .AW(AW)) u_align (
    .i_funct3  (r_f3),
    .i_addr_lo (r_lo),
    .i_rdata   (bus.mem_rdata),
    .o_data    (w_load)
  );

  always_comb begin
    w_wdata = r_alu;
    unique case (r_sel)
      SEL_ALU: w_wdata = r_alu;
      SEL_MEM: w_wdata = w_load;
      SEL_PC4: w_wdata = r_pc4;
      SEL_CSR: w_wdata = r_csr;
      default: w_wdata = r_alu;
    endcase
  end

  assign bus.rf_we        = w_commit && r_rw && (r_rd != '0);
  assign bus.rf_waddr     = r_rd;
  assign bus.rf_wdata     = w_wdata;
  assign bus.retire_valid = w_commit;
  assign bus.instret      = r_instret;

endmodule
